ssd_scan_controller: RTL
========================

Name: ssd_scan_controller

Overview:
- Parametrised seven-segment scan engine for the Nexys boards; the successor to the hard-wired 8-digit mux and hex decoder in the game top level.
- Generalises digit count and scan rate.
- Adds frame-coherent input snapshotting, per-digit enable and decimal point, leading-zero suppression, PWM brightness, and anti-ghosting dead time.
- Sits between game/status logic and the An*/Ca..Cg/Dp pins.

Parameters:
- NUM_DIGITS, 8, number of digits/anodes scanned (2..16).
- SCAN_DIV_W, 14, prescaler width; each digit slot lasts 2^SCAN_DIV_W clocks.
- BRIGHT_W, 4, brightness control width (must be < SCAN_DIV_W).
- DEAD_CYCLES, 16, clocks at the start of each slot with all anodes off (must be < 2^SCAN_DIV_W).

Ports:
- Clk, in, 1, system clock (100 MHz).
- Reset, in, 1, synchronous active-high reset.
- digits_in, in, 4*NUM_DIGITS, hex nibble per digit; digit i = bits [4i+3:4i]; digit 0 is rightmost.
- digit_en, in, NUM_DIGITS, 1 = digit may light.
- dp_in, in, NUM_DIGITS, 1 = decimal point lit for that digit.
- lz_suppress, in, 1, 1 = blank leading zeros.
- brightness, in, BRIGHT_W, PWM duty code; all ones = full.
- An, out, NUM_DIGITS, anodes, active-low, registered.
- Cathodes, out, 8, {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low, registered.
- scan_idx, out, clog2(NUM_DIGITS), index of the digit slot currently being scanned.
- frame_tick, out, 1, one-cycle pulse when the shadow registers load.

Behaviour:
- Reset (synchronous, Reset=1 at posedge):
  - presc=0, scan_idx=0, An=all 1, Cathodes=8'hFF, frame_tick=0.
  - Shadow registers are cleared and load_pending=1.
  - Reset asserted mid-slot or mid-frame aborts the scan; nothing carries over.
- Prescaler:
  - presc (SCAN_DIV_W bits) increments every clock.
  - When presc is all ones, scan_idx advances on the same edge.
  - scan_idx wraps from NUM_DIGITS-1 to 0, so NUM_DIGITS need not be a power of 2.
- Snapshot:
  - Shadow copies of digits_in, digit_en, dp_in, lz_suppress and brightness load on any edge where load_pending=1, or where presc is all ones and scan_idx=NUM_DIGITS-1 (the frame wrap).
  - The same edge sets frame_tick=1 for exactly one cycle and clears load_pending.
  - The first load happens on the first clock after Reset deasserts.
  - Input changes mid-frame are invisible until the next frame wrap (no tearing).
- Lit condition for the slot digit i = scan_idx. All of the following must hold, otherwise An is all ones:
  - shadow digit_en[i]=1.
  - presc >= DEAD_CYCLES.
  - presc[SCAN_DIV_W-1 -: BRIGHT_W] <= shadow brightness.
- When lit, An = ~(1<<i), i.e. exactly one anode low. At most one anode is ever low.
- Disabled digits still consume their slot time, so the refresh rate stays constant.
- Leading-zero suppression:
  - Digit i>0 is lz-blank when shadow lz_suppress=1 and every shadow nibble j>=i is 0.
  - Digit 0 is never lz-blank, so an all-zero value shows a single "0".
  - An lz-blank digit drives segments a..g off (1), but Dp still follows dp_in[i] and the anode still lights.
- Segment font (abcdefg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Dp bit = ~shadow dp_in[i].
  - When no digit is lit, Cathodes=8'hFF.
- Latency: An/Cathodes are registered and reflect the presc/scan_idx state of the previous cycle (1-cycle latency). scan_idx is the live counter.
- Brightness: duty per slot is roughly (brightness+1)/2^BRIGHT_W, minus the dead time. brightness=0 gives minimum, not off; use digit_en for off.

Test Plan:
(Bench parameters: NUM_DIGITS=4, SCAN_DIV_W=4, BRIGHT_W=2, DEAD_CYCLES=2.)
1. Reset 3 cycles, then digits_in=16'h12AF, digit_en=4'hF, dp_in=0, brightness=3 -> frame_tick on the first post-reset cycle.
   - Slot 0: An=4'b1110, Cathodes=8'b01110001 (F) for presc 2..15.
   - Slot 3: An=4'b0111, Cathodes=8'b10011111 (1).
   - An=4'hF during presc 0..1 of every slot.
2. Change digits_in to 16'h3333 at mid-slot 1 -> displayed values stay 12AF until the wrap. frame_tick fires once per 64 cycles and the new value shows from slot 0.
3. digits_in=16'h0040, lz_suppress=1, dp_in=4'b1000 -> digit 3 anode active with Cathodes=8'b11111110 (dp only).
   - Digit 2: Cathodes=8'hFF with anode active.
   - Digit 1: shows 4.
   - Digit 0: shows 0 (not blanked).
4. digit_en=4'b0101 -> An bits 1 and 3 never go low. Slots 1 and 3 still last 16 cycles and scan_idx still steps 0..3.
5. brightness=0 -> each lit window is presc 2..3 (2 cycles). brightness=1 -> presc 2..7 (6 cycles).
6. Assert Reset mid-slot 2 -> next edge: An=4'hF, Cathodes=8'hFF, scan_idx=0. After release, the shadow reloads with frame_tick on the first cycle.

Source files
------------

// File: rtl/ssd_scan_controller.sv
// Seven-segment scan engine: frame-coherent snapshot, per-digit enable/dp,
// leading-zero blanking, PWM brightness and anti-ghosting dead time.
module ssd_scan_controller #(
   parameter  int NUM_DIGITS  = 8,
   parameter  int SCAN_DIV_W  = 14,
   parameter  int BRIGHT_W    = 4,
   parameter  int DEAD_CYCLES = 16,
   localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_suppress,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   An,
   output logic [7:0]              Cathodes,
   output logic [IDX_W-1:0]        scan_idx,
   output logic                    frame_tick
);

   logic [SCAN_DIV_W-1:0]   presc;
   logic                    load_pending;
   logic [4*NUM_DIGITS-1:0] sh_digits;
   logic [NUM_DIGITS-1:0]   sh_en;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic                    sh_lz;
   logic [BRIGHT_W-1:0]     sh_bright;

   logic                    presc_max;
   logic                    last_slot;
   logic                    load;
   logic [NUM_DIGITS-1:0]   lz_blank;
   logic [3:0]              nib;
   logic                    lit;
   logic [6:0]              seg;

   assign presc_max = &presc;
   assign last_slot = (scan_idx == IDX_W'(NUM_DIGITS - 1));
   assign load      = load_pending | (presc_max & last_slot);

   // Slot prescaler and digit index, wrapping at NUM_DIGITS-1.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         presc    <= '0;
         scan_idx <= '0;
      end else begin
         presc <= presc + 1'b1;
         if (presc_max)
            scan_idx <= last_slot ? '0 : scan_idx + 1'b1;
      end
   end

   // Shadow snapshot at frame wrap (or first cycle after reset).
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sh_digits    <= '0;
         sh_en        <= '0;
         sh_dp        <= '0;
         sh_lz        <= 1'b0;
         sh_bright    <= '0;
         load_pending <= 1'b1;
         frame_tick   <= 1'b0;
      end else begin
         frame_tick <= load;
         if (load) begin
            sh_digits    <= digits_in;
            sh_en        <= digit_en;
            sh_dp        <= dp_in;
            sh_lz        <= lz_suppress;
            sh_bright    <= brightness;
            load_pending <= 1'b0;
         end
      end
   end

   // Leading-zero mask: blank while every nibble from the top down is zero.
   always_comb begin
      logic zero_run;
      lz_blank = '0;
      zero_run = sh_lz;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run    = zero_run & (sh_digits[4*i +: 4] == 4'h0);
         lz_blank[i] = zero_run & (i != 0);
      end
   end

   // Current slot nibble, lit window and segment font.
   always_comb begin
      nib = sh_digits[{scan_idx, 2'b00} +: 4];
      lit = sh_en[scan_idx]
          && (presc >= SCAN_DIV_W'(DEAD_CYCLES))
          && (presc[SCAN_DIV_W-1 -: BRIGHT_W] <= sh_bright);
      seg = 7'h7F;
      unique case (nib)
         4'h0: seg = 7'b0000001;
         4'h1: seg = 7'b1001111;
         4'h2: seg = 7'b0010010;
         4'h3: seg = 7'b0000110;
         4'h4: seg = 7'b1001100;
         4'h5: seg = 7'b0100100;
         4'h6: seg = 7'b0100000;
         4'h7: seg = 7'b0001111;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0000100;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b1100000;
         4'hC: seg = 7'b0110001;
         4'hD: seg = 7'b1000010;
         4'hE: seg = 7'b0110000;
         4'hF: seg = 7'b0111000;
      endcase
      if (lz_blank[scan_idx])
         seg = 7'h7F;
   end

   // Registered pin drive; everything dark outside the lit window.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         An       <= '1;
         Cathodes <= 8'hFF;
      end else if (lit) begin
         An       <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << scan_idx);
         Cathodes <= {seg, ~sh_dp[scan_idx]};
      end else begin
         An       <= '1;
         Cathodes <= 8'hFF;
      end
   end

endmodule
